// File: rtl/mmio_timer_periph_pkg.sv
// Shared constants for the memory-mapped timer peripheral.
//   - default base address of the peripheral window
//   - byte offsets of each register inside the window
//   - bit positions inside the TCON register
package mmio_timer_periph_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h4000_0000;

  localparam logic [4:0] OFF_TH      = 5'h00;
  localparam logic [4:0] OFF_TL      = 5'h04;
  localparam logic [4:0] OFF_TCON    = 5'h08;
  localparam logic [4:0] OFF_LED     = 5'h0C;
  localparam logic [4:0] OFF_SW      = 5'h10;
  localparam logic [4:0] OFF_SYSTICK = 5'h14;

  localparam int TCON_EN  = 0;
  localparam int TCON_IE  = 1;
  localparam int TCON_IRQ = 2;

endpackage

// File: rtl/mmio_timer_periph_timer.sv
// Reloadable 32-bit up-counter with sticky interrupt status.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   th_we/tl_we/tcon_we: one-cycle register write enables (already decoded)
//   wdata              : store data
//   th, tl, tcon       : current register contents
// A software write to TL or TCON overrides the hardware update of that
// register in the same cycle. A reload always uses the TH value held before
// the edge, so a same-cycle TH write only affects later reloads.
module mmio_timer_periph_timer
  import mmio_timer_periph_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        th_we,
  input  logic        tl_we,
  input  logic        tcon_we,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;

  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;

    // Hardware update first; software writes below overwrite it.
    if (tcon_q[TCON_EN]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d = th_q;
        if (tcon_q[TCON_IE]) begin
          tcon_d[TCON_IRQ] = 1'b1;
        end
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end

    if (th_we)   th_d   = wdata;
    if (tl_we)   tl_d   = wdata;
    if (tcon_we) tcon_d = wdata[2:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th   = th_q;
  assign tl   = tl_q;
  assign tcon = tcon_q;

endmodule

// File: rtl/mmio_timer_periph.sv
// MEM-stage peripheral: timer, system tick, LEDs and synchronised switches.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   Addr       : effective byte address (ALU result)
//   WriteData  : store data
//   MemRead    : load strobe; ReadData is valid in the same cycle
//   MemWrite   : store strobe; every cycle it is high performs one write
//   ReadData   : combinational load data, 0 when not reading or unmapped
//   IRQ        : timer interrupt status (TCON bit 2)
//   led        : LED register
//   switch     : asynchronous board switches
// Strobe semantics: MemRead/MemWrite are per-cycle enables with no
// handshake; both may be high together, the load then returns pre-edge data.
module mmio_timer_periph
  import mmio_timer_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter int          LED_W     = 8,
  parameter int          SW_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Addr,
  input  logic [31:0]      WriteData,
  input  logic             MemRead,
  input  logic             MemWrite,
  output logic [31:0]      ReadData,
  output logic             IRQ,
  output logic [LED_W-1:0] led,
  input  logic [SW_W-1:0]  switch
);

  logic [4:0]  off;
  logic        hit;
  logic        wr_hit;
  logic [31:0] th, tl;
  logic [2:0]  tcon;

  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      systick_q, systick_d;
  logic [SW_W-1:0]  sw_meta_q, sw_meta_d;
  logic [SW_W-1:0]  sw_sync_q, sw_sync_d;
  logic [31:0]      led_ext, sw_ext;

  assign off    = Addr[4:0];
  // Offsets 0x18/0x1C lie inside the 32-byte block but are unmapped.
  assign hit    = (Addr[31:5] == BASE_ADDR[31:5]) && (Addr[1:0] == 2'b00)
                  && (off <= OFF_SYSTICK);
  assign wr_hit = MemWrite && hit;

  mmio_timer_periph_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .th_we   (wr_hit && (off == OFF_TH)),
    .tl_we   (wr_hit && (off == OFF_TL)),
    .tcon_we (wr_hit && (off == OFF_TCON)),
    .wdata   (WriteData),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon)
  );

  always_comb begin
    led_d     = led_q;
    systick_d = systick_q + 32'd1;
    sw_meta_d = switch;
    sw_sync_d = sw_meta_q;
    if (wr_hit && (off == OFF_LED)) begin
      led_d = WriteData[LED_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= '0;
      systick_q <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      led_q     <= led_d;
      systick_q <= systick_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
    end
  end

  always_comb begin
    led_ext              = '0;
    led_ext[LED_W-1:0]   = led_q;
    sw_ext               = '0;
    sw_ext[SW_W-1:0]     = sw_sync_q;
    ReadData             = '0;
    if (MemRead && hit) begin
      case (off)
        OFF_TH:      ReadData = th;
        OFF_TL:      ReadData = tl;
        OFF_TCON:    ReadData = {29'd0, tcon};
        OFF_LED:     ReadData = led_ext;
        OFF_SW:      ReadData = sw_ext;
        OFF_SYSTICK: ReadData = systick_q;
        default:     ReadData = '0;
      endcase
    end
  end

  assign IRQ = tcon[TCON_IRQ];
  assign led = led_q;

endmodule

// File: tb/tb_mmio_timer_periph.sv
module tb_mmio_timer_periph;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_TICK = 32'h4000_0014;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ReadData;
  logic        IRQ;
  logic [7:0]  led;
  logic [7:0]  switch;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_irq;
  logic [31:0] obs_led;
  logic [31:0] tb_tick;

  mmio_timer_periph dut (
    .clk       (clk),
    .reset     (reset),
    .Addr      (Addr),
    .WriteData (WriteData),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .ReadData  (ReadData),
    .IRQ       (IRQ),
    .led       (led),
    .switch    (switch)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle count for SYSTICK.
  always @(posedge clk) begin
    if (reset) tb_tick <= 32'd0;
    else       tb_tick <= tb_tick + 32'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One bus cycle: drive at posedge+1, push expected ReadData, sample at
  // negedge, pop and compare, then finish at the next posedge+1.
  task automatic cyc(input string tag, input logic [31:0] a, input logic [31:0] wd,
                     input logic r, input logic w, input logic [31:0] exp_rd);
    logic [31:0] e;
    exp_q.push_back(exp_rd);
    Addr      = a;
    WriteData = wd;
    MemRead   = r;
    MemWrite  = w;
    @(negedge clk);
    obs_irq = {31'd0, IRQ};
    obs_led = {24'd0, led};
    e = exp_q.pop_front();
    chk(tag, ReadData, e);
    @(posedge clk);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp_rd);
    cyc(tag, a, 32'd0, 1'b1, 1'b0, exp_rd);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd);
    cyc("wr_rdata_zero", a, wd, 1'b0, 1'b1, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; Addr = '0; WriteData = '0; MemRead = 1'b0; MemWrite = 1'b0;
    switch = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_irq", {31'd0, IRQ}, 32'd0);
    chk("rst_led", {24'd0, led}, 32'd0);
    chk("rst_rdata", ReadData, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // SYSTICK counts from 0 after reset
    rd("tick0", A_TICK, 32'd0);
    rd("tick1", A_TICK, 32'd1);
    chk("tick_irq", obs_irq, 32'd0);

    // reload with interrupt enabled
    wr(A_TH, 32'hFFFF_FFFD);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'd3);
    rd("t1_tl_a", A_TL, 32'hFFFF_FFFE);
    rd("t1_tl_b", A_TL, 32'hFFFF_FFFF);
    chk("t1_irq_pre", obs_irq, 32'd0);
    rd("t1_tcon_set", A_TCON, 32'd7);
    chk("t1_irq_set", obs_irq, 32'd1);
    rd("t1_tl_reload", A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'd3);
    rd("t1_tcon_clr", A_TCON, 32'd3);
    chk("t1_irq_clr", obs_irq, 32'd0);
    wr(A_TCON, 32'd0);
    rd("t1_tl_stop", A_TL, 32'hFFFF_FFFF);
    rd("t1_tl_hold", A_TL, 32'hFFFF_FFFF);

    // reload with interrupt disabled
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'd1);
    rd("t2_tl_a", A_TL, 32'hFFFF_FFFE);
    rd("t2_tl_b", A_TL, 32'hFFFF_FFFF);
    rd("t2_tcon", A_TCON, 32'd1);
    chk("t2_irq", obs_irq, 32'd0);
    rd("t2_tl_reload", A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'd0);
    rd("t2_tl_stop", A_TL, 32'hFFFF_FFFD);

    // TL write in the reload cycle; IRQ still sets
    wr(A_TH, 32'h0000_1234);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'd3);
    wr(A_TL, 32'h0000_0010);
    rd("t3_tl_sw", A_TL, 32'h0000_0010);
    chk("t3_irq", obs_irq, 32'd1);
    rd("t3_tcon", A_TCON, 32'd7);

    // TCON write in the reload cycle drops the IRQ set
    wr(A_TCON, 32'd0);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'd3);
    wr(A_TCON, 32'd2);
    rd("t4_tcon", A_TCON, 32'd2);
    chk("t4_irq", obs_irq, 32'd0);
    rd("t4_tl_reload", A_TL, 32'h0000_1234);

    // TH write in the reload cycle: reload uses old TH
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'd1);
    wr(A_TH, 32'h0000_5555);
    rd("t5_tl_oldth", A_TL, 32'h0000_1234);
    rd("t5_th_new", A_TH, 32'h0000_5555);
    wr(A_TCON, 32'd0);
    rd("t5_tl_stop", A_TL, 32'h0000_1237);

    // LED and decode
    wr(A_LED, 32'h0000_00A5);
    rd("led_rd", A_LED, 32'h0000_00A5);
    chk("led_out", obs_led, 32'h0000_00A5);
    rd("unaligned", 32'h4000_0002, 32'd0);
    rd("outside", 32'h4000_0020, 32'd0);
    rd("hole_rd", 32'h4000_0018, 32'd0);
    cyc("no_read", A_LED, 32'd0, 1'b0, 1'b0, 32'd0);
    wr(32'h4000_0018, 32'hFFFF_FFFF);
    rd("hole_th", A_TH, 32'h0000_5555);
    rd("hole_tl", A_TL, 32'h0000_1237);
    rd("hole_tcon", A_TCON, 32'd0);
    rd("hole_led", A_LED, 32'h0000_00A5);
    cyc("rdwr_old", A_LED, 32'h0000_003C, 1'b1, 1'b1, 32'h0000_00A5);
    rd("rdwr_new", A_LED, 32'h0000_003C);
    wr(A_TICK, 32'hDEAD_BEEF);
    rd("tick_wr_ign", A_TICK, tb_tick);

    // switch synchroniser
    switch = 8'h3C;
    rd("sw_e0", A_SW, 32'd0);
    rd("sw_e1", A_SW, 32'd0);
    rd("sw_e2", A_SW, 32'h0000_003C);
    switch = 8'($urandom_range(0, 255));
    rd("sw_e0_rnd", A_SW, 32'h0000_003C);
    rd("sw_e1_rnd", A_SW, 32'h0000_003C);
    rd("sw_e2_rnd", A_SW, {24'd0, switch});

    // reset mid-count
    wr(A_TH, 32'h0000_0777);
    wr(A_TL, 32'h0000_0100);
    wr(A_TCON, 32'd3);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rd("rst2_tl", A_TL, 32'd0);
    rd("rst2_tl_stay", A_TL, 32'd0);
    rd("rst2_tcon", A_TCON, 32'd0);
    chk("rst2_irq", obs_irq, 32'd0);
    chk("rst2_led", obs_led, 32'd0);
    rd("rst2_th", A_TH, 32'd0);
    rd("rst2_tick", A_TICK, tb_tick);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
